// File: rtl/calc_ctrl_pkg.sv
// Shared definitions for the calculator entry controller.
//   - state encodings of the entry sequencer (S_A..S_SHOW, 3-bit)
//   - operator codes OP_ADD..OP_DIV
//   - default operand/operator widths
//   - key_t and decode_key(): collapses the keypad strobes of one cycle into
//     the single event that wins (eq > op > din); clr is handled separately
//     because it acts like a reset.
package calc_ctrl_pkg;

    localparam int DEF_DW  = 8;
    localparam int DEF_OPW = 2;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_EXEC = 3'd2,
        S_SHOW = 3'd3
    } state_t;

    localparam logic [DEF_OPW-1:0] OP_ADD = 2'd0;
    localparam logic [DEF_OPW-1:0] OP_SUB = 2'd1;
    localparam logic [DEF_OPW-1:0] OP_MUL = 2'd2;
    localparam logic [DEF_OPW-1:0] OP_DIV = 2'd3;

    typedef enum logic [1:0] {
        KEY_NONE = 2'd0,
        KEY_DIN  = 2'd1,
        KEY_OP   = 2'd2,
        KEY_EQ   = 2'd3
    } key_t;

    function automatic key_t decode_key(input logic din_v, input logic op_v, input logic eq_v);
        if (eq_v)       return KEY_EQ;
        else if (op_v)  return KEY_OP;
        else if (din_v) return KEY_DIN;
        else            return KEY_NONE;
    endfunction

endpackage

// File: rtl/operand_entry_ctrl_if.sv
// Bus bundle of the operand entry controller.
//   keypad side : din, din_valid, op_in, op_valid, eq_valid, clr
//   ALU side    : alu_done, alu_result, alu_err (in); alu_start, operand_word, op_code (out)
//   display side: memo, result, result_valid, busy, error, state (out)
// slave  = the controller, master = whatever drives keypad/ALU (e.g. a bench).
interface operand_entry_ctrl_if #(
    parameter int DW  = 8,
    parameter int OPW = 2
);
    logic [DW-1:0]   din;
    logic            din_valid;
    logic [OPW-1:0]  op_in;
    logic            op_valid;
    logic            eq_valid;
    logic            clr;
    logic            alu_done;
    logic [2*DW-1:0] alu_result;
    logic            alu_err;

    logic            memo;
    logic [2*DW-1:0] operand_word;
    logic [OPW-1:0]  op_code;
    logic            alu_start;
    logic [2*DW-1:0] result;
    logic            result_valid;
    logic            busy;
    logic            error;
    logic [2:0]      state;

    modport slave (
        input  din, din_valid, op_in, op_valid, eq_valid, clr,
        input  alu_done, alu_result, alu_err,
        output memo, operand_word, op_code, alu_start,
        output result, result_valid, busy, error, state
    );

    modport master (
        output din, din_valid, op_in, op_valid, eq_valid, clr,
        output alu_done, alu_result, alu_err,
        input  memo, operand_word, op_code, alu_start,
        input  result, result_valid, busy, error, state
    );
endinterface

// File: rtl/operand_entry_ctrl_exec_timer.sv
// exec_timer: saturating cycle counter for the execute phase.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear (next count = 0), wins over en
//   en       : count one cycle
//   tc       : the increment on this cycle brings the count to TIMEOUT,
//              i.e. this is the TIMEOUT-th enabled cycle since the clear
module exec_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (int'(count) < TIMEOUT)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = en && (int'(count) == TIMEOUT - 1);

endmodule

// File: rtl/operand_entry_ctrl.sv
// operand_entry_ctrl: sequences keypad entry of A (high byte) and B (low
// byte), latches the operator, launches the ALU and holds its result.
//   clk, rst : clock, synchronous active-high reset
//   bus      : operand_entry_ctrl_if.slave (keypad, ALU and display signals)
// Every output is a register or a decode of the state register.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_A    | entering operand A (high byte), memo=0
//   S_B    | operator latched, entering operand B (low byte), memo=1
//   S_EXEC | ALU launched, waiting for alu_done or timeout, busy=1
//   S_SHOW | result/error held for display
module operand_entry_ctrl
    import calc_ctrl_pkg::*;
#(
    parameter int DW      = calc_ctrl_pkg::DEF_DW,
    parameter int OPW     = calc_ctrl_pkg::DEF_OPW,
    parameter int TIMEOUT = 255
) (
    input logic clk,
    input logic rst,
    operand_entry_ctrl_if.slave bus
);
    state_t          state_q, state_d;
    logic [2*DW-1:0] word_q, word_d;
    logic [OPW-1:0]  opc_q, opc_d;
    logic            start_q, start_d;
    logic [2*DW-1:0] result_q, result_d;
    logic            rv_q, rv_d;
    logic            err_q, err_d;
    logic            timer_clr;
    logic            timer_tc;
    key_t            key;

    exec_timer #(.TIMEOUT(TIMEOUT)) u_exec_timer (
        .clk (clk),
        .rst (rst),
        .clr (bus.clr || timer_clr),
        .en  (state_q == S_EXEC),
        .tc  (timer_tc)
    );

    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            state_q  <= S_A;
            word_q   <= '0;
            opc_q    <= '0;
            start_q  <= 1'b0;
            result_q <= '0;
            rv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            opc_q    <= opc_d;
            start_q  <= start_d;
            result_q <= result_d;
            rv_q     <= rv_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        opc_d     = opc_q;
        start_d   = 1'b0;
        result_d  = result_q;
        rv_d      = rv_q;
        err_d     = err_q;
        timer_clr = 1'b0;
        key       = decode_key(bus.din_valid, bus.op_valid, bus.eq_valid);

        case (state_q)
            S_A: begin
                if (key == KEY_DIN) begin
                    word_d[2*DW-1:DW] = bus.din;
                end else if (key == KEY_OP) begin
                    opc_d   = bus.op_in;
                    state_d = S_B;
                end
            end
            S_B: begin
                if (key == KEY_DIN) begin
                    word_d[DW-1:0] = bus.din;
                end else if (key == KEY_OP) begin
                    opc_d = bus.op_in;
                end else if (key == KEY_EQ) begin
                    state_d   = S_EXEC;
                    start_d   = 1'b1;
                    timer_clr = 1'b1;
                end
            end
            S_EXEC: begin
                // alu_done has precedence over a timeout in the same cycle
                if (bus.alu_done) begin
                    result_d = bus.alu_result;
                    rv_d     = 1'b1;
                    err_d    = bus.alu_err;
                    state_d  = S_SHOW;
                end else if (timer_tc) begin
                    err_d   = 1'b1;
                    state_d = S_SHOW;
                end
            end
            S_SHOW: begin
                if (key == KEY_DIN) begin
                    word_d  = {bus.din, {DW{1'b0}}};
                    rv_d    = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_A;
                end else if (key == KEY_OP) begin
                    // chaining: previous result's low byte becomes A
                    word_d  = {result_q[DW-1:0], {DW{1'b0}}};
                    opc_d   = bus.op_in;
                    rv_d    = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_B;
                end else if (key == KEY_EQ) begin
                    rv_d      = 1'b0;
                    err_d     = 1'b0;
                    start_d   = 1'b1;
                    timer_clr = 1'b1;
                    state_d   = S_EXEC;
                end
            end
            default: begin
                state_d = S_A;
            end
        endcase
    end

    assign bus.memo         = (state_q == S_B);
    assign bus.busy         = (state_q == S_EXEC);
    assign bus.state        = state_q;
    assign bus.operand_word = word_q;
    assign bus.op_code      = opc_q;
    assign bus.alu_start    = start_q;
    assign bus.result       = result_q;
    assign bus.result_valid = rv_q;
    assign bus.error        = err_q;

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Bench for operand_entry_ctrl (TIMEOUT=4): directed scenarios with literal
// expectations, then random keypad/ALU traffic against a behavioural model.
module tb_operand_entry_ctrl;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;
    bit   check_en = 1'b0;
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   n_starts = 0;

    operand_entry_ctrl_if #(.DW(8), .OPW(2)) bus ();

    operand_entry_ctrl #(.DW(8), .OPW(2), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // behavioural model: stage numbers are the documented state codes
    int         m_stage;
    int         m_age;
    logic [7:0] m_a, m_b;
    logic [1:0] m_op;
    logic [15:0] m_res;
    bit         m_rv, m_err, m_start;

    always @(posedge clk) begin
        int kind;
        if (rst || bus.clr) begin
            m_stage = 0; m_age = 0; m_a = 0; m_b = 0; m_op = 0;
            m_res = 0; m_rv = 0; m_err = 0; m_start = 0;
        end else begin
            kind = bus.eq_valid ? 3 : bus.op_valid ? 2 : bus.din_valid ? 1 : 0;
            m_start = 0;
            if (m_stage == 0) begin
                if (kind == 1) m_a = bus.din;
                else if (kind == 2) begin m_op = bus.op_in; m_stage = 1; end
            end else if (m_stage == 1) begin
                if (kind == 1) m_b = bus.din;
                else if (kind == 2) m_op = bus.op_in;
                else if (kind == 3) begin m_stage = 2; m_start = 1; m_age = 0; end
            end else if (m_stage == 2) begin
                m_age = m_age + 1;
                if (bus.alu_done) begin
                    m_res = bus.alu_result; m_rv = 1; m_err = bus.alu_err; m_stage = 3;
                end else if (m_age >= TO) begin
                    m_err = 1; m_stage = 3;
                end
            end else begin
                if (kind == 1) begin
                    m_a = bus.din; m_b = 0; m_rv = 0; m_err = 0; m_stage = 0;
                end else if (kind == 2) begin
                    m_a = m_res[7:0]; m_b = 0; m_op = bus.op_in;
                    m_rv = 0; m_err = 0; m_stage = 1;
                end else if (kind == 3) begin
                    m_rv = 0; m_err = 0; m_stage = 2; m_start = 1; m_age = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.alu_start === 1'b1) n_starts++;
        if (check_en) begin
            chk("model.state",        32'(bus.state),        32'(m_stage));
            chk("model.memo",         32'(bus.memo),         32'(m_stage == 1));
            chk("model.busy",         32'(bus.busy),         32'(m_stage == 2));
            chk("model.operand_word", 32'(bus.operand_word), {16'h0, m_a, m_b});
            chk("model.op_code",      32'(bus.op_code),      32'(m_op));
            chk("model.alu_start",    32'(bus.alu_start),    32'(m_start));
            chk("model.result",       32'(bus.result),       32'(m_res));
            chk("model.result_valid", 32'(bus.result_valid), 32'(m_rv));
            chk("model.error",        32'(bus.error),        32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.clr = 1'b0;
        bus.din_valid = 1'b0;
        bus.op_valid = 1'b0;
        bus.eq_valid = 1'b0;
        bus.alu_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.din = '0; bus.din_valid = 0; bus.op_in = '0; bus.op_valid = 0;
        bus.eq_valid = 0; bus.clr = 0; bus.alu_done = 0; bus.alu_result = '0; bus.alu_err = 0;
        tick();
        check_en = 1'b1;
        chk("rst.state", 32'(bus.state), 0);
        chk("rst.word", 32'(bus.operand_word), 0);
        chk("rst.rv", 32'(bus.result_valid), 0);

        // basic calculation 0x12 + 0x34, ALU answers three cycles after start
        bus.din = 8'h12; bus.din_valid = 1; tick();
        chk("basic.memo_a", 32'(bus.memo), 0);
        bus.op_in = 2'd0; bus.op_valid = 1; tick();
        chk("basic.memo_b", 32'(bus.memo), 1);
        bus.din = 8'h34; bus.din_valid = 1; tick();
        chk("basic.word", 32'(bus.operand_word), 32'h1234);
        bus.eq_valid = 1; tick();
        chk("basic.start", 32'(bus.alu_start), 1);
        chk("basic.busy", 32'(bus.busy), 1);
        tick();
        chk("basic.start_off", 32'(bus.alu_start), 0);
        tick(); tick();
        bus.alu_done = 1; bus.alu_result = 16'h0046; bus.alu_err = 0; tick();
        chk("basic.result", 32'(bus.result), 32'h0046);
        chk("basic.rv", 32'(bus.result_valid), 1);
        chk("basic.busy_show", 32'(bus.busy), 0);
        chk("basic.err", 32'(bus.error), 0);
        chk("basic.nstarts", 32'(n_starts), 1);

        // chaining with OP_SUB
        bus.op_in = 2'd1; bus.op_valid = 1; tick();
        chk("chain.word", 32'(bus.operand_word), 32'h4600);
        chk("chain.op", 32'(bus.op_code), 1);
        chk("chain.state", 32'(bus.state), 1);
        chk("chain.rv", 32'(bus.result_valid), 0);

        // sync reset beats eq_valid in S_B
        rst = 1; bus.eq_valid = 1; tick();
        chk("srst.state", 32'(bus.state), 0);
        tick();
        chk("srst.nstarts", 32'(n_starts), 1);

        // overwrite and priority
        bus.din = 8'h05; bus.din_valid = 1; tick();
        bus.din = 8'h07; bus.din_valid = 1; tick();
        chk("ovr.word", 32'(bus.operand_word), 32'h0700);
        bus.din = 8'h99; bus.din_valid = 1; bus.op_in = 2'd2; bus.op_valid = 1; tick();
        chk("prio.state", 32'(bus.state), 1);
        chk("prio.word", 32'(bus.operand_word), 32'h0700);
        chk("prio.op", 32'(bus.op_code), 2);

        // timeout: no alu_done, error 4 cycles after the start pulse
        bus.eq_valid = 1; tick();
        chk("to.start", 32'(bus.alu_start), 1);
        tick(); tick(); tick();
        chk("to.err_early", 32'(bus.error), 0);
        chk("to.state_early", 32'(bus.state), 2);
        tick();
        chk("to.err", 32'(bus.error), 1);
        chk("to.rv", 32'(bus.result_valid), 0);
        chk("to.state", 32'(bus.state), 3);
        chk("to.result", 32'(bus.result), 0);

        // relaunch, then clear mid-execution and a late alu_done
        bus.eq_valid = 1; tick();
        chk("clr.err_entry", 32'(bus.error), 0);
        chk("clr.busy", 32'(bus.busy), 1);
        tick();
        bus.clr = 1; tick();
        chk("clr.state", 32'(bus.state), 0);
        chk("clr.word", 32'(bus.operand_word), 0);
        chk("clr.busy_off", 32'(bus.busy), 0);
        bus.alu_done = 1; bus.alu_result = 16'h1111; tick();
        chk("clr.result", 32'(bus.result), 0);
        chk("clr.rv", 32'(bus.result_valid), 0);
        chk("clr.nstarts", 32'(n_starts), 3);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            rst            = ($urandom_range(199) == 0);
            bus.clr        = ($urandom_range(59) == 0);
            bus.din        = 8'($urandom);
            bus.din_valid  = ($urandom_range(3) == 0);
            bus.op_in      = 2'($urandom);
            bus.op_valid   = ($urandom_range(5) == 0);
            bus.eq_valid   = ($urandom_range(5) == 0);
            bus.alu_done   = ($urandom_range(3) == 0);
            bus.alu_result = 16'($urandom);
            bus.alu_err    = ($urandom_range(3) == 0);
            tick();
        end
        tick();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/operand_entry_ctrl.md
Name: operand_entry_ctrl

Overview:
- Sequences keypad entry of a two-operand calculation into the 16-bit operand word. High byte holds operand A; low byte holds operand B.
- Drives the memo select of the byte-routing stage: 0 routes keypad data to the high byte, 1 routes it to the low byte.
- Latches the operator, launches the ALU with a start pulse, waits for completion with a timeout, and holds the result for display.
- Sits between the keypad decoder and the ALU/display path.

Parameters:
- DW, 8: operand byte width.
- OPW, 2: operator code width.
- TIMEOUT, 255: maximum cycles in S_EXEC before an error is flagged (must be at least 1).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- din  in  DW  keypad operand value
- din_valid  in  1  one-cycle strobe: operand key
- op_in  in  OPW  operator code
- op_valid  in  1  one-cycle strobe: operator key
- eq_valid  in  1  one-cycle strobe: equals key
- clr  in  1  one-cycle strobe: clear
- alu_done  in  1  ALU completion strobe
- alu_result  in  2*DW  ALU result
- alu_err  in  1  ALU error, qualified by alu_done
- memo  out  1  byte-route select (0 = high byte/A, 1 = low byte/B)
- operand_word  out  2*DW  assembled {A,B}
- op_code  out  OPW  latched operator
- alu_start  out  1  one-cycle launch pulse
- result  out  2*DW  held result
- result_valid  out  1  result available
- busy  out  1  high in S_EXEC
- error  out  1  ALU error or timeout
- state  out  3  current state (debug)

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=S_A, memo=0, operand_word=0, op_code=0, alu_start=0, result=0, result_valid=0, busy=0, error=0, timer=0.
- Reset mid-operation discards everything. A late alu_done is ignored.
- All outputs are registered or decoded from the state register only. There is no combinational path from inputs to outputs.
- memo=1 only in S_B. busy=1 only in S_EXEC.
- Per-cycle event priority: clr > eq_valid > op_valid > din_valid. Lower-priority strobes in the same cycle are dropped.
- clr in any state: same effect as reset on the next edge, including aborting S_EXEC.
- S_A (enter A):
  - din_valid: operand_word[15:8] <= din. Stays in S_A; repeated keys overwrite.
  - op_valid: op_code <= op_in, go to S_B.
  - eq_valid: ignored.
- S_B (enter B):
  - din_valid: operand_word[7:0] <= din. Overwrites.
  - op_valid: op_code replaced, stays in S_B.
  - eq_valid: go to S_EXEC. alu_start=1 for exactly the first cycle in S_EXEC. timer <= 0.
  - If B was never keyed, B = 0.
- S_EXEC:
  - din_valid and op_valid are ignored. eq_valid is ignored, with no relaunch.
  - timer increments every cycle.
  - alu_done: result <= alu_result, result_valid <= 1, error <= alu_err, go to S_SHOW. alu_done is accepted in the same cycle as alu_start (ALU latency 0 allowed).
  - timer reaches TIMEOUT with no alu_done: error <= 1, result unchanged, result_valid stays 0, go to S_SHOW.
  - If alu_done and the timeout coincide, alu_done wins.
- S_SHOW:
  - Result held stable.
  - din_valid: new calculation. operand_word <= {din, 0}, result_valid <= 0, error <= 0, go to S_A.
  - op_valid (chaining): operand_word <= {result[7:0], 0}, op_code <= op_in, result_valid <= 0, error <= 0, go to S_B.
  - eq_valid: relaunch with the same operand_word and op_code via S_EXEC, with result_valid <= 0 and error <= 0 on entering S_EXEC.
- alu_done outside S_EXEC is ignored.
- State encoding is 3 bits: S_A=0, S_B=1, S_EXEC=2, S_SHOW=3. Encodings 4–7 are illegal and recover to S_A on the next edge.
- Timer width is clog2(TIMEOUT+1). The timer saturates and never wraps.

Decomposition:
- Shared package calc_ctrl_pkg holds:
  - state encodings S_A..S_SHOW;
  - operator codes OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3;
  - default widths DW=8, OPW=2.
- One natural sub-module, exec_timer: a saturating cycle counter with clear and enable inputs and a terminal-count output at TIMEOUT.
- The FSM and operand/result registers stay in operand_entry_ctrl.

Test Plan:
- Basic calculation: rst; din 0x12 with din_valid; op_valid op=OP_ADD; din 0x34; eq_valid; ALU returns alu_done=1 with alu_result=0x0046 three cycles later.
  - Required: memo 0→1 after op_valid; operand_word=0x1234; a single-cycle alu_start; result=0x0046; result_valid=1; busy low in S_SHOW.
- Overwrite and priority: in S_A send din 0x05 then 0x07 → operand_word[15:8]=0x07. Assert op_valid and din_valid in the same cycle → operator taken, din dropped, state S_B.
- Timeout: with TIMEOUT=4 and alu_done never asserted → error=1 exactly 4 cycles after alu_start; result_valid=0; state S_SHOW.
- Clear mid-operation: clr in S_EXEC, then alu_done one cycle later → all outputs at reset values; result stays 0.
- Chaining: from S_SHOW with result=0x0046, op_valid op=OP_SUB → operand_word=0x4600, op_code=1, state S_B, result_valid=0.
- Sync reset: assert rst together with eq_valid in S_B → next state S_A, alu_start never pulses.
